// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        VALID  = 3'd5,
        BREAK  = 3'd6
    } rx_state_t;

    localparam int DATA_LEN_MIN = 5;
    localparam int DATA_LEN_MAX = 9;

    function automatic logic in_frame_state(rx_state_t s);
        return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Oversample position and bit index counters for one UART frame.
module uart_rx_bit_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] last_edge;

    assign last_edge = prescale - PRESCALE_W'(1);
    assign bit_end   = en && (edge_cnt == last_edge);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (bit_end) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side UART frame controller: walks start/data/parity/stop bits with a
// runtime-configurable frame shape, flags per-frame errors and line breaks.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | start bit, glitch check at bit end
// DATA   | data bits 1..data_len, deserializer shifting
// PARITY | parity bit, parity check at bit end
// STOP   | one or two stop bits, stop check at each bit end
// VALID  | single-cycle frame-accepted state
// BREAK  | line held low through a whole frame, wait for line high
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int MAX_DATA   = 9,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [BIT_CNT_W-1:0]  data_len,
    input  logic                  PAR_EN,
    input  logic                  stop2,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  deser_en,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  break_det
);

    rx_state_t             state, next_state;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic [BIT_CNT_W-1:0]  cfg_len;
    logic                  cfg_par;
    logic                  cfg_stop2;
    logic                  line_zero;
    logic [BIT_CNT_W-1:0]  len_clamped;
    logic [BIT_CNT_W-1:0]  s1_idx;
    logic                  in_frame;
    logic                  bit_end;
    logic                  timer_clr;
    logic                  start_req;
    logic                  start_entry;
    logic                  set_pe;
    logic                  set_fe;

    assign in_frame    = in_frame_state(state);
    assign start_req   = !RX_IN && (Prescale != '0);
    assign start_entry = (next_state == START) && (state != START);
    assign timer_clr   = (next_state == IDLE) || (next_state == VALID) || (next_state == BREAK);
    assign s1_idx      = cfg_len + BIT_CNT_W'(1) + BIT_CNT_W'(cfg_par);

    // Out-of-range lengths are pinned to the legal window so the frame always ends.
    always_comb begin
        len_clamped = data_len;
        if (data_len < BIT_CNT_W'(DATA_LEN_MIN)) begin
            len_clamped = BIT_CNT_W'(DATA_LEN_MIN);
        end else if (data_len > BIT_CNT_W'(MAX_DATA)) begin
            len_clamped = BIT_CNT_W'(MAX_DATA);
        end
    end

    uart_rx_bit_timer #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (in_frame),
        .clr      (timer_clr),
        .prescale (cfg_prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    always_comb begin
        next_state = state;
        set_pe     = 1'b0;
        set_fe     = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) next_state = START;
            end
            START: begin
                if (bit_end) next_state = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt == cfg_len)) next_state = cfg_par ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) begin
                    if (par_err) begin
                        next_state = IDLE;
                        set_pe     = 1'b1;
                    end else begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == s1_idx) begin
                        if (stp_err) begin
                            if (line_zero) begin
                                next_state = BREAK;
                            end else begin
                                next_state = IDLE;
                                set_fe     = 1'b1;
                            end
                        end else begin
                            next_state = cfg_stop2 ? STOP : VALID;
                        end
                    end else if (stp_err) begin
                        next_state = IDLE;
                        set_fe     = 1'b1;
                    end else begin
                        next_state = VALID;
                    end
                end
            end
            VALID: begin
                next_state = start_req ? START : IDLE;
            end
            BREAK: begin
                if (RX_IN) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= next_state;
            data_valid <= (next_state == VALID);
            frame_err  <= set_fe;
            parity_err <= set_pe;
        end
    end

    // Frame shape is frozen at the start edge so mid-frame config writes are harmless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_prescale <= '0;
            cfg_len      <= BIT_CNT_W'(DATA_LEN_MIN);
            cfg_par      <= 1'b0;
            cfg_stop2    <= 1'b0;
            line_zero    <= 1'b0;
        end else begin
            if (start_entry) begin
                cfg_prescale <= Prescale;
                cfg_len      <= len_clamped;
                cfg_par      <= PAR_EN;
                cfg_stop2    <= stop2;
                line_zero    <= 1'b1;
            end else if (((state == DATA) || (state == PARITY)) && RX_IN) begin
                line_zero    <= 1'b0;
            end
        end
    end

    assign dat_samp_en = in_frame;
    assign strt_chk_en = (state == START);
    assign par_chk_en  = (state == PARITY);
    assign stp_chk_en  = (state == STOP);
    assign deser_en    = (state == DATA);
    assign break_det   = (state == BREAK);

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised receive controller for the UART_RX path. It replaces the fixed 8-bit control FSM and owns its own edge and bit counters. Frame shape is runtime-configurable: data length, parity enable/type and 1 or 2 stop bits. It adds per-frame error flags and line-break detection, and sits between the data sampler / checkers and the deserializer.

Parameters:
PRESCALE_W, 6, width of Prescale and edge_cnt
MAX_DATA, 9, maximum data bits per frame (legal data_len 5..MAX_DATA)
BIT_CNT_W, 4, width of bit_cnt; must hold 1+MAX_DATA+1+2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
RX_IN  in  1  synchronised serial line
Prescale  in  PRESCALE_W  oversampling clocks per bit; legal 4..2^PRESCALE_W-1; 0 holds block in IDLE
data_len  in  BIT_CNT_W  data bits per frame, 5..MAX_DATA
PAR_EN  in  1  parity bit present
stop2  in  1  0 = one stop bit, 1 = two stop bits
strt_glitch  in  1  from start checker, valid at end of start bit
par_err  in  1  from parity checker, valid at end of parity bit
stp_err  in  1  from stop checker, valid at end of each stop bit
edge_cnt  out  PRESCALE_W  oversample position within current bit
bit_cnt  out  BIT_CNT_W  bit index in frame (start = 0)
dat_samp_en  out  1  sampler enable
strt_chk_en, par_chk_en, stp_chk_en  out  1 each  checker enables
deser_en  out  1  deserializer shift enable
data_valid  out  1  one-cycle pulse, frame accepted
frame_err  out  1  one-cycle pulse, stop-bit error (non-break)
parity_err  out  1  one-cycle pulse, parity error
break_det  out  1  level, line held low through a whole frame

Behaviour:
- Reset: state IDLE; edge_cnt = 0; bit_cnt = 0; all outputs 0. Reset mid-frame abandons the frame with no pulses.
- Config inputs are sampled on IDLE->START and held in internal registers for the whole frame. Changes mid-frame have no effect.
- Counters:
  - Run only in START/DATA/PARITY/STOP.
  - edge_cnt increments each clk. At edge_cnt == Prescale-1 ("bit end") it wraps to 0 and bit_cnt increments.
  - Both counters clear to 0 on any transition into IDLE, VALID or BREAK.
- Derived bit indices: last data bit LD = data_len; parity bit P = LD+1; first stop bit S1 = LD+1+PAR_EN; S2 = S1+1.
- States and transitions:
  - IDLE: RX_IN==0 and Prescale!=0 -> START.
  - START: at bit end, strt_glitch -> IDLE (no pulse); otherwise -> DATA.
  - DATA: at bit end with bit_cnt==LD -> PARITY if PAR_EN, else STOP.
  - PARITY: at bit end, par_err -> IDLE with parity_err pulse; otherwise -> STOP.
  - STOP:
    - At bit end of S1, stp_err: -> BREAK if line_zero, else -> IDLE with frame_err pulse.
    - At bit end of S1, no error: -> VALID if !stop2, else stay for S2.
    - At bit end of S2: stp_err -> IDLE with frame_err pulse; otherwise -> VALID.
  - VALID: exactly one cycle, data_valid=1. RX_IN==0 -> START (back-to-back frame); otherwise -> IDLE.
  - BREAK: break_det=1. Stays until RX_IN==1, then -> IDLE on the next clock. No data_valid.
- line_zero flag: set on entry to START. Cleared on any cycle in DATA or PARITY where RX_IN==1.
- Output decode is Moore, from registered state:
  - dat_samp_en and enable-type outputs: high in START/DATA/PARITY/STOP.
  - deser_en: DATA only.
  - strt_chk_en: START only. par_chk_en: PARITY only. stp_chk_en: STOP only.
- Error and valid pulses are registered. They appear the cycle after the decision and are mutually exclusive.
- Illegal state encodings -> IDLE.

Decomposition:
- Shared package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP, VALID, BREAK), 3-bit encoding, legal data_len bounds.
- One natural sub-module: uart_rx_bit_timer, holding the edge/bit counters with clear, enable and a bit_end strobe. The FSM stays in uart_rx_ctrl.

Test Plan:
- Prescale=8, data_len=8, PAR_EN=0, stop2=0, clean frame 0x55 -> deser_en high for 64 clocks; data_valid pulses once, 10 bit-times after the start edge.
- Prescale=16, data_len=7, PAR_EN=1, par_err=1 at parity bit end -> parity_err pulse; no data_valid; state IDLE; counters 0.
- Prescale=8, data_len=5, stop2=1, stp_err=1 only on S2 -> frame_err pulse after S2 bit end; no data_valid.
- RX_IN held low for 12 bit-times, stp_err=1 at S1 -> break_det rises. It stays high until RX_IN returns high, then drops the cycle after; no frame_err.
- Two back-to-back frames with RX_IN=0 in the VALID cycle -> VALID->START directly; two data_valid pulses; second frame decodes correctly.
- Assert reset_n=0 mid-DATA (bit_cnt=4) -> all outputs 0 immediately. After release, next frame decodes normally.
